// File: rtl/player_missile.sv
// Player missile: launches from the ship on a fire press, climbs one step
// per frame, tests overlap against a single enemy box every cycle, and
// enforces a frame-counted cooldown between shots.
module player_missile #(
    parameter logic [9:0]  speed_p    = 10'd8,
    parameter logic [9:0]  width_p    = 10'd2,
    parameter logic [9:0]  height_p   = 10'd10,
    parameter logic [9:0]  offset_p   = 10'd19,
    parameter logic [7:0]  cooldown_p = 8'd15,
    parameter logic [11:0] color_p    = {4'hF, 4'hF, 4'h0}
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       frame_i,
    input  logic       fire_i,
    input  logic [9:0] player_left_i,
    input  logic [9:0] player_top_i,
    input  logic [9:0] enemy_left_i,
    input  logic [9:0] enemy_right_i,
    input  logic [9:0] enemy_top_i,
    input  logic [9:0] enemy_bot_i,
    input  logic       enemy_dead_i,
    output logic       hit_o,
    output logic       active_o,
    output logic [9:0] left_pos_o,
    output logic [9:0] right_pos_o,
    output logic [9:0] top_pos_o,
    output logic [9:0] bot_pos_o,
    output logic [3:0] missile_red_o,
    output logic [3:0] missile_green_o,
    output logic [3:0] missile_blue_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLYING = 2'd1,
        HIT    = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [9:0] left_q, left_d;
    logic [9:0] top_q, top_d;
    logic [7:0] cool_q, cool_d;
    logic       fire_q;
    logic       press;
    logic       launch_ok;
    logic       overlap;

    // Box edges are derived from the stored top-left corner.
    assign left_pos_o  = left_q;
    assign top_pos_o   = top_q;
    assign right_pos_o = left_q + width_p - 10'd1;
    assign bot_pos_o   = top_q + height_p - 10'd1;

    // Rising edge only, so a held button never auto-fires.
    assign press     = fire_i & ~fire_q;
    assign launch_ok = press && (cool_q == 8'd0) && (player_top_i >= height_p);

    assign overlap = (left_q <= enemy_right_i) && (right_pos_o >= enemy_left_i) &&
                     (top_q <= enemy_bot_i) && (bot_pos_o >= enemy_top_i);

    assign hit_o    = (state_q == HIT);
    assign active_o = (state_q == FLYING) || (state_q == HIT);
    assign {missile_red_o, missile_green_o, missile_blue_o} = active_o ? color_p : 12'h000;

    // State, position, cooldown and fire-edge registers.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            left_q  <= 10'd0;
            top_q   <= 10'd0;
            cool_q  <= 8'd0;
            fire_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            left_q  <= left_d;
            top_q   <= top_d;
            cool_q  <= cool_d;
            fire_q  <= fire_i;
        end
    end

    // Next-state logic; a collision wins over a same-cycle frame step.
    always_comb begin
        state_d = state_q;
        left_d  = left_q;
        top_d   = top_q;
        cool_d  = cool_q;
        case (state_q)
            IDLE: begin
                if (frame_i && (cool_q != 8'd0))
                    cool_d = cool_q - 8'd1;
                if (launch_ok) begin
                    state_d = FLYING;
                    left_d  = player_left_i + offset_p;
                    top_d   = player_top_i - height_p;
                end
            end
            FLYING: begin
                if (overlap && !enemy_dead_i) begin
                    state_d = HIT;
                    cool_d  = cooldown_p;
                end else if (frame_i) begin
                    if (top_q < speed_p) begin
                        state_d = IDLE;
                        cool_d  = cooldown_p;
                    end else begin
                        top_d = top_q - speed_p;
                    end
                end
            end
            HIT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_player_missile.sv
// Scoreboard bench for player_missile: stimulus queues the expected events,
// a negedge monitor detects launch/hit/end/probe events and checks them.
module tb_player_missile;

    localparam logic [9:0]  W      = 10'd2;
    localparam logic [9:0]  H      = 10'd10;
    localparam logic [11:0] RGB_ON = 12'hFF0;
    localparam logic [3:0]  EV_PROBE  = 4'd1;
    localparam logic [3:0]  EV_LAUNCH = 4'd2;
    localparam logic [3:0]  EV_HIT    = 4'd3;
    localparam logic [3:0]  EV_END    = 4'd4;

    typedef struct packed {
        logic [3:0]  kind;
        logic        active;
        logic        hit;
        logic [9:0]  left;
        logic [9:0]  right;
        logic [9:0]  top;
        logic [9:0]  bot;
        logic [11:0] rgb;
    } ev_t;

    logic       clk_i = 1'b0;
    logic       reset_ni = 1'b0;
    logic       frame_i = 1'b0;
    logic       fire_i = 1'b0;
    logic [9:0] player_left_i = 10'd300;
    logic [9:0] player_top_i = 10'd440;
    logic [9:0] enemy_left_i = 10'd0;
    logic [9:0] enemy_right_i = 10'd0;
    logic [9:0] enemy_top_i = 10'd0;
    logic [9:0] enemy_bot_i = 10'd0;
    logic       enemy_dead_i = 1'b1;
    logic       hit_o, active_o;
    logic [9:0] left_pos_o, right_pos_o, top_pos_o, bot_pos_o;
    logic [3:0] missile_red_o, missile_green_o, missile_blue_o;

    player_missile dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .frame_i(frame_i), .fire_i(fire_i),
        .player_left_i(player_left_i), .player_top_i(player_top_i),
        .enemy_left_i(enemy_left_i), .enemy_right_i(enemy_right_i),
        .enemy_top_i(enemy_top_i), .enemy_bot_i(enemy_bot_i),
        .enemy_dead_i(enemy_dead_i), .hit_o(hit_o), .active_o(active_o),
        .left_pos_o(left_pos_o), .right_pos_o(right_pos_o),
        .top_pos_o(top_pos_o), .bot_pos_o(bot_pos_o),
        .missile_red_o(missile_red_o), .missile_green_o(missile_green_o),
        .missile_blue_o(missile_blue_o)
    );

    always #5 clk_i = ~clk_i;

    ev_t  sb_q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    logic probe = 1'b0;
    logic prev_active = 1'b0;
    logic done = 1'b0;
    logic mon_done = 1'b0;

    function automatic string kname(input logic [3:0] k);
        case (k)
            EV_PROBE:  return "probe";
            EV_LAUNCH: return "launch";
            EV_HIT:    return "hit";
            EV_END:    return "end";
            default:   return "none";
        endcase
    endfunction

    function automatic ev_t mk(input logic [3:0] k, input logic act, input logic h,
                               input logic [9:0] l, input logic [9:0] t);
        ev_t e;
        e.kind   = k;
        e.active = act;
        e.hit    = h;
        e.left   = l;
        e.right  = l + W - 10'd1;
        e.top    = t;
        e.bot    = t + H - 10'd1;
        e.rgb    = act ? RGB_ON : 12'h000;
        return e;
    endfunction

    task automatic expect_ev(input logic [3:0] k, input logic act, input logic h,
                             input int l, input int t);
        sb_q.push_back(mk(k, act, h, l[9:0], t[9:0]));
    endtask

    task automatic check_ev(input logic [3:0] k);
        ev_t a, e;
        a.kind   = k;
        a.active = active_o;
        a.hit    = hit_o;
        a.left   = left_pos_o;
        a.right  = right_pos_o;
        a.top    = top_pos_o;
        a.bot    = bot_pos_o;
        a.rgb    = {missile_red_o, missile_green_o, missile_blue_o};
        n_chk++;
        if (sb_q.size() == 0) begin
            $display("FAIL unexpected_%s @%0t: got act=%0b hit=%0b l=%0d t=%0d, want no event",
                     kname(k), $time, a.active, a.hit, a.left, a.top);
        end else begin
            e = sb_q.pop_front();
            if (a !== e)
                $display("FAIL %s @%0t: got %s act=%0b hit=%0b l=%0d r=%0d t=%0d b=%0d rgb=%h, want %s act=%0b hit=%0b l=%0d r=%0d t=%0d b=%0d rgb=%h",
                         kname(e.kind), $time, kname(a.kind), a.active, a.hit, a.left, a.right,
                         a.top, a.bot, a.rgb, kname(e.kind), e.active, e.hit, e.left, e.right,
                         e.top, e.bot, e.rgb);
            else
                n_pass++;
        end
    endtask

    // Monitor: detect output events away from the active edge and score them.
    always @(negedge clk_i) begin
        if (probe) check_ev(EV_PROBE);
        if (hit_o) check_ev(EV_HIT);
        else if (active_o && !prev_active) check_ev(EV_LAUNCH);
        else if (!active_o && prev_active) check_ev(EV_END);
        prev_active = active_o;
        if (done && !mon_done) begin
            n_chk++;
            if (sb_q.size() == 0) n_pass++;
            else $display("FAIL pending_events: got %0d outstanding, want 0", sb_q.size());
            mon_done = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic frame();
        frame_i = 1'b1;
        tick();
        frame_i = 1'b0;
    endtask

    task automatic press();
        fire_i = 1'b1;
        tick();
        fire_i = 1'b0;
        tick();
    endtask

    task automatic do_probe();
        probe = 1'b1;
        tick();
        probe = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) tick();
        reset_ni = 1'b1;
        tick();
        expect_ev(EV_PROBE, 0, 0, 0, 0);
        do_probe();

        // Basic launch, first frame step, flight off the top edge
        expect_ev(EV_LAUNCH, 1, 0, 319, 430);
        press();
        frame();
        expect_ev(EV_PROBE, 1, 0, 319, 422);
        do_probe();
        repeat (52) frame();
        expect_ev(EV_PROBE, 1, 0, 319, 6);
        do_probe();
        expect_ev(EV_END, 0, 0, 319, 6);
        frame();

        // Cooldown: a press on the 14th frame is dropped, after the 15th it launches
        repeat (14) frame();
        press();
        frame();
        expect_ev(EV_LAUNCH, 1, 0, 319, 430);
        press();

        // Hit with a frame pulse in the overlap cycle: position frozen at 102
        enemy_left_i = 10'd300; enemy_right_i = 10'd339;
        enemy_top_i  = 10'd100; enemy_bot_i   = 10'd109;
        enemy_dead_i = 1'b0;
        expect_ev(EV_HIT, 1, 1, 319, 102);
        expect_ev(EV_END, 0, 0, 319, 102);
        repeat (40) frame();
        frame_i = 1'b1;
        tick();
        tick();
        frame_i = 1'b0;
        repeat (3) tick();

        // Enemy right edge equal to missile left still hits
        repeat (15) frame();
        enemy_left_i = 10'd280; enemy_right_i = 10'd319;
        expect_ev(EV_LAUNCH, 1, 0, 319, 430);
        press();
        expect_ev(EV_HIT, 1, 1, 319, 102);
        expect_ev(EV_END, 0, 0, 319, 102);
        repeat (41) frame();
        repeat (3) tick();

        // Held button through flight and cooldown; enemy dies mid-flight
        repeat (15) frame();
        enemy_left_i = 10'd300; enemy_right_i = 10'd339;
        expect_ev(EV_LAUNCH, 1, 0, 319, 430);
        fire_i = 1'b1;
        tick();
        repeat (10) frame();
        enemy_dead_i = 1'b1;
        repeat (43) frame();
        expect_ev(EV_END, 0, 0, 319, 6);
        frame();
        repeat (20) frame();
        fire_i = 1'b0;
        tick();
        expect_ev(EV_LAUNCH, 1, 0, 319, 430);
        press();

        // Reset mid-flight aborts, clears cooldown, relaunch right away
        repeat (3) frame();
        expect_ev(EV_PROBE, 1, 0, 319, 406);
        do_probe();
        expect_ev(EV_END, 0, 0, 0, 0);
        reset_ni = 1'b0;
        tick();
        reset_ni = 1'b1;
        tick();
        expect_ev(EV_LAUNCH, 1, 0, 319, 430);
        press();
        repeat (53) frame();
        expect_ev(EV_END, 0, 0, 319, 6);
        frame();

        // Launch height boundary: top 9 dropped, top 10 launches at y 0
        repeat (15) frame();
        player_top_i = 10'd9;
        press();
        player_top_i = 10'd10;
        expect_ev(EV_LAUNCH, 1, 0, 319, 0);
        press();
        expect_ev(EV_END, 0, 0, 319, 0);
        frame();
        repeat (3) tick();

        done = 1'b1;
        repeat (3) tick();
        if (!mon_done) $display("FAIL monitor_done: got 0, want 1");
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
